// File: rtl/tmip_result_collector_pkg.sv
// tmip_result_collector_pkg: shared widths, FSM state, size encodings and word-count mapping
package tmip_result_collector_pkg;

    localparam int TMIP_WORD_W = 20;
    localparam int TMIP_IDX_W  = 8;

    // Image-size encodings shared with the TMIP core
    localparam logic [1:0] SIZE_4X4   = 2'd0;
    localparam logic [1:0] SIZE_8X8   = 2'd1;
    localparam logic [1:0] SIZE_16X16 = 2'd2;

    typedef enum logic {IDLE, RECV} state_e;

    // Number of result words in a frame; encoding 3 is treated as 16x16
    function automatic logic [TMIP_IDX_W:0] words_for(input logic [1:0] size);
        return size == SIZE_4X4 ? (TMIP_IDX_W+1)'(16) :
               size == SIZE_8X8 ? (TMIP_IDX_W+1)'(64) : (TMIP_IDX_W+1)'(256);
    endfunction

endpackage

// File: rtl/tmip_result_collector_if.sv
// tmip_result_collector_if: config, serial result stream and parallel word outputs
interface tmip_result_collector_if
    import tmip_result_collector_pkg::*;
#(
    parameter int WORD_W = TMIP_WORD_W,
    parameter int IDX_W  = TMIP_IDX_W
);
    logic              cfg_valid;
    logic [1:0]        cfg_size;
    logic              out_valid;
    logic              out_value;
    logic              word_valid;
    logic [WORD_W-1:0] word_data;
    logic [IDX_W-1:0]  word_idx;
    logic              frame_done;
    logic [WORD_W-1:0] max_value;
    logic [IDX_W-1:0]  max_idx;
    logic              err;

    modport slave (
        input  cfg_valid, cfg_size, out_valid, out_value,
        output word_valid, word_data, word_idx, frame_done, max_value, max_idx, err
    );

    modport master (
        output cfg_valid, cfg_size, out_valid, out_value,
        input  word_valid, word_data, word_idx, frame_done, max_value, max_idx, err
    );
endinterface

// File: rtl/tmip_result_collector_bit_deser.sv
// tmip_result_collector_bit_deser: MSB-first serial-to-parallel with partial-word drop detection
module tmip_result_collector_bit_deser
    import tmip_result_collector_pkg::*;
#(
    parameter int WORD_W = TMIP_WORD_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_i,
    input  logic              en_i,
    input  logic              bit_valid_i,
    input  logic              bit_i,
    output logic              word_stb_o,
    output logic              drop_stb_o,
    output logic [WORD_W-1:0] word_o
);
    localparam int BCNT_W = $clog2(WORD_W);
    localparam logic [BCNT_W-1:0] LAST = BCNT_W'(WORD_W - 1);

    // The final bit bypasses the register, so only WORD_W-1 bits are stored
    logic [WORD_W-2:0] sr_q, sr_d;
    logic [BCNT_W-1:0] cnt_q, cnt_d;

    assign word_stb_o = en_i & bit_valid_i & (cnt_q == LAST);
    assign drop_stb_o = en_i & ~bit_valid_i & (cnt_q != '0);
    assign word_o     = {sr_q, bit_i};

    // Shift on each valid bit; restart on completed word, dropped word or clear
    always_comb begin
        sr_d  = clr_i | drop_stb_o | word_stb_o ? '0 :
                en_i & bit_valid_i ? {sr_q[WORD_W-3:0], bit_i} : sr_q;
        cnt_d = clr_i | drop_stb_o | word_stb_o ? '0 :
                en_i & bit_valid_i ? cnt_q + 1'b1 : cnt_q;
    end

    // Shift register and bit counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q  <= '0;
            cnt_q <= '0;
        end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/tmip_result_collector.sv
// tmip_result_collector: reassembles TMIP serial results, tracks frame max and flags protocol errors
module tmip_result_collector
    import tmip_result_collector_pkg::*;
#(
    parameter int WORD_W = TMIP_WORD_W,
    parameter int IDX_W  = TMIP_IDX_W
) (
    input logic                     clk,
    input logic                     rst_n,
    tmip_result_collector_if.slave  bus
);
    state_e            state_q;
    logic [IDX_W:0]    wcnt_q, exp_q;
    logic              word_valid_q, frame_done_q, err_q;
    logic [WORD_W-1:0] word_data_q, max_value_q;
    logic [IDX_W-1:0]  word_idx_q, max_idx_q;
    logic              en, word_stb, drop_stb, new_max, last_word;
    logic [WORD_W-1:0] word;

    // A cfg_valid cycle belongs to the new frame, so any coincident bit is ignored
    assign en = (state_q == RECV) & ~bus.cfg_valid;

    tmip_result_collector_bit_deser #(.WORD_W(WORD_W)) u_deser (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr_i       (bus.cfg_valid),
        .en_i        (en),
        .bit_valid_i (bus.out_valid),
        .bit_i       (bus.out_value),
        .word_stb_o  (word_stb),
        .drop_stb_o  (drop_stb),
        .word_o      (word)
    );

    // First word of a frame always loads; later ones only on a strict increase
    always_comb begin
        new_max   = (wcnt_q == '0) | (word > max_value_q);
        last_word = (wcnt_q + 1'b1) == exp_q;
    end

    // Frame FSM with word counter, max tracker and sticky error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            wcnt_q       <= '0;
            exp_q        <= '0;
            word_valid_q <= 1'b0;
            frame_done_q <= 1'b0;
            err_q        <= 1'b0;
            word_data_q  <= '0;
            word_idx_q   <= '0;
            max_value_q  <= '0;
            max_idx_q    <= '0;
        end else begin
            word_valid_q <= 1'b0;
            frame_done_q <= 1'b0;
            if (bus.cfg_valid) begin
                state_q     <= RECV;
                exp_q       <= (IDX_W+1)'(words_for(bus.cfg_size));
                wcnt_q      <= '0;
                max_value_q <= '0;
                max_idx_q   <= '0;
                err_q       <= 1'b0;
            end else if (state_q == IDLE) begin
                if (bus.out_valid) err_q <= 1'b1;
            end else begin
                if (drop_stb) err_q <= 1'b1;
                if (word_stb) begin
                    word_valid_q <= 1'b1;
                    word_data_q  <= word;
                    word_idx_q   <= wcnt_q[IDX_W-1:0];
                    wcnt_q       <= wcnt_q + 1'b1;
                    if (new_max) begin
                        max_value_q <= word;
                        max_idx_q   <= wcnt_q[IDX_W-1:0];
                    end
                    if (last_word) begin
                        frame_done_q <= 1'b1;
                        state_q      <= IDLE;
                    end
                end
            end
        end
    end

    assign bus.word_valid = word_valid_q;
    assign bus.word_data  = word_data_q;
    assign bus.word_idx   = word_idx_q;
    assign bus.frame_done = frame_done_q;
    assign bus.max_value  = max_value_q;
    assign bus.max_idx    = max_idx_q;
    assign bus.err        = err_q;
endmodule
